// File: rtl/csa_resolve_178_pkg.sv
// csa_pkg: shared constants and types for the csa_resolve_178 carry-propagate
// resolver.
//   WIDTH   operand/result width
//   CHUNK   bits resolved per cycle
//   NCHUNK  cycles per operation, ceil(WIDTH/CHUNK)
//   LAST_W  width of the partial top chunk
//   KW      chunk counter width
//   state_t resolver FSM states
package csa_pkg;

  localparam int WIDTH = 178;
  localparam int CHUNK = 32;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  localparam int NCHUNK = ceil_div(WIDTH, CHUNK);
  localparam int LAST_W = WIDTH - (NCHUNK - 1) * CHUNK;
  localparam int KW     = $clog2(NCHUNK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/csa_resolve_178_cpa_chunk.sv
// cpa_chunk: combinational CHUNK-bit ripple adder with carry in/out.
//   a, b  addend chunks
//   cin   carry in
//   sum   CHUNK-bit sum
//   cout  carry out of bit CHUNK-1
module cpa_chunk
  import csa_pkg::*;
(
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] full;

  assign full        = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign {cout, sum} = full;

endmodule

// File: rtl/csa_resolve_178.sv
// csa_resolve_178: sequential carry-propagate resolver. Converts a carry-save
// pair (c, s) into the binary value c + s, CHUNK bits per cycle, using a single
// chunk adder and a registered carry.
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_ready   operand handshake (in_ready only in IDLE)
//   c, s                 carry and sum vectors, WIDTH bits
//   out_valid, out_ready result handshake (out_valid only in DONE)
//   sum                  (c + s) mod 2^WIDTH
//   ovf                  bit WIDTH of c + s
module csa_resolve_178
  import csa_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  localparam int PADW = NCHUNK * CHUNK - WIDTH;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q;
  logic             carry_q;
  logic [WIDTH-1:0] c_q, s_q;
  logic [WIDTH-1:0] sum_q;
  logic             ovf_q;

  logic [NCHUNK*CHUNK-1:0] c_pad, s_pad;
  logic [CHUNK-1:0]        a_k, b_k, chunk_sum;
  logic                    chunk_cout, chunk_carry, last;
  logic                    accept;

  // Zero-extend the operands so the top chunk reads as a full CHUNK-bit word.
  assign c_pad = {{PADW{1'b0}}, c_q};
  assign s_pad = {{PADW{1'b0}}, s_q};
  assign last  = (k_q == KW'(NCHUNK - 1));

  always_comb begin
    a_k = '0;
    b_k = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k_q == KW'(i)) begin
        a_k = c_pad[i*CHUNK +: CHUNK];
        b_k = s_pad[i*CHUNK +: CHUNK];
      end
    end
  end

  cpa_chunk u_chunk (
    .a    (a_k),
    .b    (b_k),
    .cin  (carry_q),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  // With zero-extended inputs, the carry out of the partial top chunk lands
  // in bit LAST_W of the chunk sum rather than in the adder's cout.
  assign chunk_carry = last ? chunk_sum[LAST_W] : chunk_cout;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        k_q     <= '0;
        carry_q <= 1'b0;
        ovf_q   <= 1'b0;
      end else if (state_q == BUSY) begin
        for (int i = 0; i < NCHUNK - 1; i++) begin
          if (k_q == KW'(i)) sum_q[i*CHUNK +: CHUNK] <= chunk_sum;
        end
        if (last) begin
          sum_q[WIDTH-1 -: LAST_W] <= chunk_sum[LAST_W-1:0];
          ovf_q                    <= chunk_carry;
          k_q                      <= '0;
          carry_q                  <= 1'b0;
        end else begin
          carry_q <= chunk_carry;
          k_q     <= k_q + 1'b1;
        end
      end
    end
  end

  // Operand capture: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      c_q <= c;
      s_q <= s;
    end
  end

  assign sum = sum_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_csa_resolve_178.sv
// Testbench for csa_resolve_178: directed and random operand pairs checked
// against a 179-bit reference sum held in a scoreboard queue.
module tb_csa_resolve_178;
  import csa_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] c = '0;
  logic [WIDTH-1:0] s = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             ovf;

  int checks = 0;
  int failures = 0;
  logic [WIDTH:0] q[$];

  csa_resolve_178 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c         (c),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] rand178();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[WIDTH-1:0];
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [WIDTH-1:0] cv, input logic [WIDTH-1:0] sv,
                          output bit ok);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    ok = in_ready;
    c = cv;
    s = sv;
    in_valid = 1'b1;
    q.push_back({1'b0, cv} + {1'b0, sv});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
    end
    checks++;
    if (sum !== '0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_data got sum=%0h ovf=%b exp 0 0", sum, ovf);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_minimal();
    bit ok;
    int cyc;
    logic [WIDTH:0] exp;
    out_ready = 1'b1;
    start_op('0, WIDTH'(1), ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL min_accept got in_ready=0 exp 1"); end
    wait_out(cyc);
    checks++;
    if (cyc !== 6) begin failures++; $display("FAIL min_latency got %0d exp 6", cyc); end
    exp = q.pop_front();
    checks++;
    if ({ovf, sum} !== exp) begin
      failures++;
      $display("FAIL min_sum got %0h exp %0h", {ovf, sum}, exp);
    end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL min_excl got in_ready=%b exp 0", in_ready); end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL min_idle got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_boundaries();
    logic [WIDTH-1:0] cv[4];
    logic [WIDTH-1:0] sv[4];
    logic [WIDTH:0]   exp;
    bit ok;
    int cyc;
    cv[0] = '0; cv[0][WIDTH-1] = 1'b1;  sv[0] = cv[0];        // top-bit overflow
    cv[1] = WIDTH'(2);                  sv[1] = '1;           // full ripple
    cv[2] = '0; cv[2][31] = 1'b1;       sv[2] = cv[2];        // chunk boundary
    cv[3] = '1;                         sv[3] = '1;           // all ones
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_op(cv[i], sv[i], ok);
      wait_out(cyc);
      exp = q.pop_front();
      checks++;
      if (!out_valid || {ovf, sum} !== exp) begin
        failures++;
        $display("FAIL boundary%0d got v=%b %0h exp %0h", i, out_valid, {ovf, sum}, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    logic [WIDTH:0] exp;
    out_ready = 1'b0;
    start_op(rand178(), rand178(), ok);
    wait_out(cyc);
    exp = q.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {ovf, sum} !== exp) begin
        failures++;
        $display("FAIL bp_hold%0d got v=%b r=%b %0h exp v=1 r=0 %0h", i, out_valid, in_ready,
                 {ovf, sum}, exp);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_midop();
    bit ok;
    int cyc;
    logic [WIDTH:0] exp;
    logic [WIDTH:0] dropped;
    out_ready = 1'b1;
    start_op('1, WIDTH'(5), ok);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dropped = q.pop_back();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL midrst got r=%b v=%b sum=%0h ovf=%b exp 1 0 0 0 (dropped %0h)",
               in_ready, out_valid, sum, ovf, dropped);
    end
    start_op(rand178(), rand178(), ok);
    wait_out(cyc);
    exp = q.pop_front();
    checks++;
    if (!out_valid || cyc !== 6 || {ovf, sum} !== exp) begin
      failures++;
      $display("FAIL midrst_next got v=%b cyc=%0d %0h exp 6 %0h", out_valid, cyc, {ovf, sum}, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int got = 0;
    int cyc = 0;
    int overlap = 0;
    int bad = 0;
    bit drv_to = 0;
    logic [WIDTH:0] exp;
    in_valid = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          int t = 0;
          c = rand178();
          s = rand178();
          while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
          end
          if (!in_ready) begin
            drv_to = 1;
            break;
          end
          q.push_back({1'b0, c} + {1'b0, s});
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        while (got < 1000 && cyc < 40000) begin
          @(negedge clk);
          cyc++;
          out_ready = 1'($urandom_range(0, 1));
          if (in_ready && out_valid) overlap++;
          if (out_valid && out_ready) begin
            got++;
            checks++;
            if (q.size() == 0) begin
              failures++;
              $display("FAIL b2b_extra got result %0h exp none", {ovf, sum});
            end else begin
              exp = q.pop_front();
              if ({ovf, sum} !== exp) begin
                failures++;
                bad++;
                if (bad < 5) $display("FAIL b2b_sum%0d got %0h exp %0h", got, {ovf, sum}, exp);
              end
            end
          end
        end
      end
    join
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got !== 1000 || q.size() !== 0 || drv_to) begin
      failures++;
      $display("FAIL b2b_count got %0d left=%0d to=%b exp 1000 0 0", got, q.size(), drv_to);
    end
    checks++;
    if (overlap !== 0) begin
      failures++;
      $display("FAIL b2b_excl got overlap=%0d exp 0", overlap);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_minimal();
    test_boundaries();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
